// File: rtl/romulus_tk1_ctrl_if.sv
// Mode-controller <-> TK1 sequencer bundle: counter commands, call request, and TK1 register controls.
// The mode controller takes the master side and the sequencer takes the slave side. No backpressure: start is ignored unless the sequencer is idle.
interface romulus_tk1_ctrl_if;
  logic         cnt_rst;
  logic         cnt_inc;
  logic [7:0]   domain_dat;
  logic         start_vld;
  logic         busy;
  logic         done_vld;
  logic [5:0]   round_dat;
  logic         tk1_sel;
  logic         tk1_en;
  logic [127:0] tk1_init_dat;

  modport master (
    output cnt_rst, cnt_inc, domain_dat, start_vld,
    input  busy, done_vld, round_dat, tk1_sel, tk1_en, tk1_init_dat
  );

  modport slave (
    input  cnt_rst, cnt_inc, domain_dat, start_vld,
    output busy, done_vld, round_dat, tk1_sel, tk1_en, tk1_init_dat
  );
endinterface

// File: rtl/romulus_tk1_ctrl.sv
// Romulus-N TK1 sequencer: 56-bit LFSR block counter, domain byte, and TK1 load/step control for one TBC call.
// A call takes 1 LOAD cycle plus ROUNDS RUN cycles, with done in the final round. Start and counter commands are dropped while busy.
module romulus_tk1_ctrl #(
  parameter int unsigned ROUNDS = 40
) (
  input logic               clk_i,
  input logic               rst_i,
  romulus_tk1_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [55:0] s_q, s_d;
  logic [7:0]  d_q, d_d;
  logic [5:0]  round_q, round_d;

  // Galois step for x^56+x^7+x^4+x^2+1; the all-zero state is never reached from 1
  function automatic logic [55:0] lfsr_step(input logic [55:0] s);
    logic [55:0] n;
    n    = {s[54:0], s[55]};
    n[7] = n[7] ^ s[55];
    n[4] = n[4] ^ s[55];
    n[2] = n[2] ^ s[55];
    return n;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= 56'h1;
      d_q     <= 8'h00;
      round_q <= 6'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    d_d          = d_q;
    round_d      = round_q;
    bus.busy     = 1'b0;
    bus.done_vld = 1'b0;
    bus.tk1_sel  = 1'b0;
    bus.tk1_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Counter update lands in the same cycle as start, so the call sees the new value
        if (bus.cnt_rst) begin
          s_d = 56'h1;
        end else if (bus.cnt_inc) begin
          s_d = lfsr_step(s_q);
        end
        if (bus.start_vld) begin
          d_d     = bus.domain_dat;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bus.busy    = 1'b1;
        bus.tk1_sel = 1'b1;
        bus.tk1_en  = 1'b1;
        round_d     = 6'd0;
        state_d     = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (round_q == LAST_ROUND) begin
          bus.done_vld = 1'b1;
          round_d      = 6'd0;
          state_d      = IDLE;
        end else begin
          bus.tk1_en = 1'b1;
          round_d    = round_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.round_dat    = round_q;
  assign bus.tk1_init_dat = {s_q[7:0], s_q[15:8], s_q[23:16], s_q[31:24],
                             s_q[39:32], s_q[47:40], s_q[55:48], d_q, 64'h0};

endmodule

// File: tb/tb_romulus_tk1_ctrl.sv
// Bench for romulus_tk1_ctrl: a driver queues the expected TK1_init per accepted start.
// A monitor pops that value at LOAD and checks the load value, round count, enable count and done timing.
module tb_romulus_tk1_ctrl;
  localparam int ROUNDS = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  romulus_tk1_ctrl_if bus_if ();

  romulus_tk1_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  int           checks   = 0;
  int           failures = 0;
  logic [127:0] sb_q[$];
  logic [55:0]  m_s = 56'h1;
  logic [7:0]   m_d = 8'h00;
  int           pcyc = 0;

  logic [127:0] exp_cur  = '0;
  bit           in_call  = 1'b0;
  int           en_cnt   = 0;
  int           since    = 0;
  int           done_cnt = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [55:0] model_step(input logic [55:0] s);
    return (s << 1) ^ (s[55] ? 56'h95 : 56'h0);
  endfunction

  function automatic logic [127:0] model_tk1(input logic [55:0] s, input logic [7:0] d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r[127 - 8*i -: 8] = s[8*i +: 8];
    r[71:64] = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.start_vld  = 1'b0;
    bus_if.cnt_inc    = 1'b0;
    bus_if.cnt_rst    = 1'b0;
    bus_if.domain_dat = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    m_s = 56'h1;
    m_d = 8'h00;
  endtask

  // Drive one accepted start; caller guarantees the DUT is idle
  task automatic issue(input logic [7:0] d, input logic inc, input logic crst);
    bus_if.domain_dat = d;
    bus_if.start_vld  = 1'b1;
    bus_if.cnt_inc    = inc;
    bus_if.cnt_rst    = crst;
    if (crst) m_s = 56'h1;
    else if (inc) m_s = model_step(m_s);
    m_d = d;
    sb_q.push_back(model_tk1(m_s, m_d));
    tick();
    bus_if.start_vld = 1'b0;
    bus_if.cnt_inc   = 1'b0;
    bus_if.cnt_rst   = 1'b0;
  endtask

  task automatic wait_done(output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 4*ROUNDS && !seen; i++) begin
      @(negedge clk);
      if (bus_if.done_vld) begin
        seen   = 1'b1;
        at_cyc = pcyc;
      end
    end
    check_eq("done_seen", 128'(seen), 128'd1);
  endtask

  always @(negedge clk) begin
    if (bus_if.tk1_sel) begin
      check_eq("load_expected", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) begin
        exp_cur = sb_q.pop_front();
        check_eq("load_tk1", bus_if.tk1_init_dat, exp_cur);
      end
      check_eq("load_round", 128'(bus_if.round_dat), 128'd0);
      in_call = 1'b1;
      en_cnt  = 0;
      since   = 0;
    end else if (in_call) begin
      since++;
    end
    if (in_call && bus_if.tk1_en) en_cnt++;
    if (bus_if.done_vld) begin
      check_eq("done_in_call", 128'(in_call), 128'd1);
      check_eq("done_latency", 128'(since), 128'(ROUNDS));
      check_eq("en_cycles", 128'(en_cnt), 128'(ROUNDS));
      check_eq("done_tk1", bus_if.tk1_init_dat, exp_cur);
      check_eq("done_round", 128'(bus_if.round_dat), 128'(ROUNDS - 1));
      in_call = 1'b0;
      done_cnt++;
    end else if (in_call && !bus_if.busy) begin
      in_call = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, da, db;
    bit found;
    clear_inputs();
    do_reset();

    // reset values, then first call with D=1A
    @(negedge clk);
    check_eq("rst_outs", 128'({bus_if.busy, bus_if.done_vld, bus_if.tk1_sel, bus_if.tk1_en, bus_if.round_dat}), 128'd0);
    check_eq("rst_tk1", bus_if.tk1_init_dat, 128'h0100_0000_0000_0000_0000_0000_0000_0000);
    tick();
    t0 = pcyc;
    issue(8'h1A, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("c1_sel", 128'({bus_if.tk1_sel, bus_if.tk1_en, bus_if.busy}), 128'b111);
    check_eq("c1_tk1", bus_if.tk1_init_dat, 128'h0100_0000_0000_001A_0000_0000_0000_0000);
    @(negedge clk);
    check_eq("c2_sel", 128'({bus_if.tk1_sel, bus_if.tk1_en}), 128'b01);
    wait_done(da);
    check_eq("c1_done_cycle", 128'(da - t0), 128'(ROUNDS + 1));
    @(negedge clk);
    check_eq("c1_idle", 128'({bus_if.busy, bus_if.tk1_en}), 128'd0);

    // counter stepping
    tick();
    bus_if.cnt_inc = 1'b1;
    m_s = model_step(m_s);
    tick();
    bus_if.cnt_inc = 1'b0;
    @(negedge clk);
    check_eq("inc1_byte", 128'(bus_if.tk1_init_dat[127:120]), 128'h02);
    check_eq("inc1_tk1", bus_if.tk1_init_dat, model_tk1(m_s, m_d));
    tick();
    bus_if.cnt_inc = 1'b1;
    for (int i = 0; i < 54; i++) begin
      m_s = model_step(m_s);
      tick();
    end
    bus_if.cnt_inc = 1'b0;
    @(negedge clk);
    check_eq("inc55_tk1", bus_if.tk1_init_dat, model_tk1(56'h80_0000_0000_0000, 8'h1A));
    tick();
    bus_if.cnt_inc = 1'b1;
    m_s = model_step(m_s);
    tick();
    bus_if.cnt_inc = 1'b0;
    @(negedge clk);
    check_eq("inc56_tk1", bus_if.tk1_init_dat, model_tk1(56'h95, 8'h1A));
    check_eq("inc56_model", bus_if.tk1_init_dat, model_tk1(m_s, m_d));

    // cnt_inc together with start, then cnt_rst beats cnt_inc
    do_reset();
    issue(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("incstart_byte", 128'(bus_if.tk1_init_dat[127:72]), 128'h02_0000_0000_0000);
    wait_done(da);
    tick();
    bus_if.cnt_rst = 1'b1;
    bus_if.cnt_inc = 1'b1;
    m_s = 56'h1;
    tick();
    clear_inputs();
    @(negedge clk);
    check_eq("rst_over_inc", bus_if.tk1_init_dat, model_tk1(56'h1, 8'h3C));

    // commands during RUN are ignored
    tick();
    issue(8'h33, 1'b1, 1'b0);
    repeat (5) tick();
    bus_if.start_vld  = 1'b1;
    bus_if.cnt_inc    = 1'b1;
    bus_if.cnt_rst    = 1'b1;
    bus_if.domain_dat = 8'hFF;
    repeat (3) tick();
    bus_if.start_vld = 1'b0;
    bus_if.cnt_inc   = 1'b0;
    bus_if.cnt_rst   = 1'b0;
    wait_done(da);
    @(negedge clk);
    check_eq("run_ign_busy", 128'(bus_if.busy), 128'd0);
    check_eq("run_ign_tk1", bus_if.tk1_init_dat, model_tk1(m_s, m_d));

    // reset mid-call abandons it; a fresh call then completes
    tick();
    issue(8'h77, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 3*ROUNDS && !found; i++) begin
      @(negedge clk);
      if (bus_if.round_dat == 6'd17 && bus_if.busy) found = 1'b1;
    end
    check_eq("round17_seen", 128'(found), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_s = 56'h1;
    m_d = 8'h00;
    check_eq("midrst_outs", 128'({bus_if.busy, bus_if.done_vld, bus_if.tk1_sel, bus_if.tk1_en, bus_if.round_dat}), 128'd0);
    check_eq("midrst_tk1", bus_if.tk1_init_dat, 128'h0100_0000_0000_0000_0000_0000_0000_0000);
    tick();
    issue(8'h5A, 1'b0, 1'b0);
    wait_done(da);

    // back-to-back calls with the minimum idle gap
    tick();
    issue(8'h1D, 1'b0, 1'b0);
    wait_done(da);
    tick();
    issue(8'h1C, 1'b0, 1'b0);
    wait_done(db);
    check_eq("b2b_gap", 128'(db - da), 128'(ROUNDS + 2));

    repeat (3) tick();
    check_eq("sb_empty", 128'(sb_q.size()), 128'd0);
    check_eq("done_total", 128'(done_cnt), 128'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/romulus_tk1_ctrl.md
# romulus_tk1_ctrl

Upstream companion of the TK1 tweakey-schedule register in the Romulus-N datapath. It owns the 56-bit LFSR block counter and the domain-separation byte, and assembles the 128-bit TK1 initial value from them. It also sequences one Skinny-128-384+ call by driving the TK1 register's load-select and enable for exactly the configured number of rounds, with a done pulse back to the mode controller.

## Interface
- ROUNDS, 40, number of TBC rounds per call (≥2)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cnt_rst  in  1  reinitialise counter to 1
- cnt_inc  in  1  step counter LFSR once
- domain  in  8  domain-separation byte D, sampled on accepted start
- start  in  1  request one TBC call
- busy  out  1  call in progress (LOAD or RUN)
- done  out  1  one-cycle pulse in final round
- round  out  6  current round index
- tk1_sel  out  1  load-select to TK1 register (1 = take TK1_init)
- tk1_en  out  1  enable to TK1 register
- TK1_init  out  128  {counter bytes, D, 64'h0}

## Operation
- Clock is clk; reset is synchronous, active-high (rst). On rst: state IDLE, LFSR s = 56'h1, D register = 8'h00, round = 0, busy = done = tk1_sel = tk1_en = 0.
- TK1_init[127:72] = {s[7:0], s[15:8], s[23:16], s[31:24], s[39:32], s[47:40], s[55:48]} (LSByte first); TK1_init[71:64] = D register; TK1_init[63:0] = 0.
- LFSR step: s' = {s[54:0], s[55]} with s'[7], s'[4], s'[2] additionally XORed with s[55] (poly x^56+x^7+x^4+x^2+1). Period 2^56−1; wraps naturally, all-zero never reached.
- Counter commands honoured only in IDLE; ignored while busy. cnt_rst has priority over cnt_inc.
- FSM states IDLE, LOAD, RUN:
  - IDLE: start=1 → LOAD; D register <= domain. Same-cycle cnt_inc/cnt_rst also applied, so the call uses the updated counter.
  - LOAD (1 cycle): tk1_sel = 1, tk1_en = 1, round = 0, busy = 1 → RUN.
  - RUN: busy = 1, tk1_sel = 0, tk1_en = 1 while round < ROUNDS−1, else 0. round increments each cycle. At round = ROUNDS−1: done = 1, next state IDLE, round <= 0.
- start outside IDLE ignored (no queuing). domain changes outside accepted start have no effect.
- rst in any state: next cycle is reset state; partial call abandoned, no done.

## Timing
- start accepted in cycle 0 → LOAD in cycle 1 (TK1 register loads at end of cycle 1) → RUN cycles 2..ROUNDS+1 with round 0..ROUNDS−1 → done in cycle ROUNDS+1 (cycle 41 for default).
- During RUN with round = r, the downstream register holds TK1 permuted r times.
- Number of tk1_en cycles per call: exactly ROUNDS (1 load + ROUNDS−1 updates).
- Earliest next accepted start: cycle ROUNDS+2 (back-to-back gap of 1 IDLE cycle).
- TK1_init is registered-state-derived, stable from LOAD through done.
- All outputs are Moore functions of state/registers, no input-to-output combinational paths.

## Test plan
- Reset, domain = 8'h1A, start → TK1_init = 128'h0100_0000_0000_001A_0000_0000_0000_0000 in LOAD; tk1_sel=1 only in cycle 1; done in cycle 41; tk1_en high cycles 1..40 exactly.
- One cnt_inc from reset → s = 56'h2, TK1_init[127:120] = 8'h02; 55 steps → s = 56'h80_0000_0000_0000; 56th step → s = 56'h95.
- cnt_inc and start in same IDLE cycle from reset → call uses s = 56'h2; cnt_rst+cnt_inc together → s = 56'h1.
- start and cnt_inc pulsed during RUN → ignored: s, D unchanged, single done, busy deasserts after cycle 41.
- rst asserted at round 17 → next cycle all outputs at reset values, s = 1, no done; new start then completes normally.
- Two calls with one IDLE gap, D = 8'h1D then 8'h1C → each TK1_init shows correct D, done twice, 42 cycles apart.
